bsg_id_pool_multi_port: RTL and testbench

//  Pool of els_p IDs with alloc_els_p allocation ports and dealloc_els_p deallocation ports per cycle.

---
 rtl/bsg_id_pool_multi_port_pick.sv | 56 +++++
 rtl/bsg_id_pool_multi_port.sv | 167 ++++++++++++++++
 tb/tb_bsg_id_pool_multi_port.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_id_pool_multi_port_pick.sv
// bsg_id_pool_multi_port_pick
//   Combinational rotate-then-select-k-lowest. The available vector is rotated
//   so that bit 0 corresponds to i_start. A cascade of alloc_els_p lowest-set-bit
//   stages then runs, each with the earlier picks masked off. Each pick is
//   finally rotated back to absolute ID positions. Stage k therefore holds the
//   k-th available ID in search order, so picks on different ports never collide.
// Ports
//   i_avail    in  els_p                  IDs that may be handed out this cycle
//   i_start    in  id_width_lp            first ID in search order
//   o_pick_oh  out alloc_els_p x els_p    one-hot pick per port (absolute ID positions)
//   o_pick_v   out alloc_els_p            port k found an ID
module bsg_id_pool_multi_port_pick #(
  parameter int els_p       = 8,
  parameter int alloc_els_p = 2,
  parameter int id_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic [els_p-1:0]                  i_avail,
  input  logic [id_width_lp-1:0]            i_start,
  output logic [alloc_els_p-1:0][els_p-1:0] o_pick_oh,
  output logic [alloc_els_p-1:0]            o_pick_v
);

  // i_start is always < els_p, so a single conditional subtract wraps the index.
  function automatic int wrap_idx(input int idx);
    return (idx >= els_p) ? idx - els_p : idx;
  endfunction

  logic [els_p-1:0] w_rot;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < els_p; i++) begin
      w_rot[i] = i_avail[wrap_idx(i + int'(i_start))];
    end
  end

  always_comb begin
    logic [els_p-1:0] remain;
    logic [els_p-1:0] low;
    remain    = w_rot;
    low       = '0;
    o_pick_oh = '0;
    o_pick_v  = '0;
    for (int k = 0; k < alloc_els_p; k++) begin
      // Isolate the lowest set bit (two's-complement trick). Then drop it from
      // the pool seen by later stages.
      low         = remain & (~remain + els_p'(1));
      remain      = remain & ~low;
      o_pick_v[k] = |low;
      for (int i = 0; i < els_p; i++) begin
        if (low[i]) o_pick_oh[k][wrap_idx(i + int'(i_start))] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_id_pool_multi_port.sv
// bsg_id_pool_multi_port
//   Pool of els_p IDs with alloc_els_p allocation ports and dealloc_els_p
//   deallocation ports per cycle. The pool supports a reserve mask, a
//   dealloc-to-alloc bypass, a registered free count, and an optional rotating
//   search start.
// Ports
//   clk_i         in   1                          clock, posedge
//   reset_i       in   1                          synchronous active-high reset
//   reserve_i     in   els_p                      IDs that must not be handed out
//   alloc_v_o     out  alloc_els_p                port k offers a valid ID
//   alloc_id_o    out  alloc_els_p*id_width_lp    ID offered on port k
//   alloc_yumi_i  in   alloc_els_p                port k consumes its offer
//   dealloc_v_i   in   dealloc_els_p              port j returns an ID
//   dealloc_id_i  in   dealloc_els_p*id_width_lp  ID returned on port j
//   free_cnt_o    out  cnt_width_lp               registered count of unallocated IDs
//   empty_o       out  1                          no ID is allocated (registered state)
// Handshake: alloc_v_o[k] and alloc_id_o[k] are computed from registered state,
//   reserve_i, and dealloc_*_i. They never depend on alloc_yumi_i.
//   alloc_yumi_i[k] may be raised only while alloc_v_o[k] is high. That consumes
//   the offered ID at the next clock edge. The ports are independent of each
//   other. A dealloc takes effect at the next edge. Its ID is offered again in
//   the same cycle.
module bsg_id_pool_multi_port #(
  parameter int els_p         = 8,
  parameter int alloc_els_p   = 2,
  parameter int dealloc_els_p = 2,
  parameter int rotate_p      = 0,
  localparam int id_width_lp  = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [els_p-1:0]                     reserve_i,
  output logic [alloc_els_p-1:0]               alloc_v_o,
  output logic [alloc_els_p*id_width_lp-1:0]   alloc_id_o,
  input  logic [alloc_els_p-1:0]               alloc_yumi_i,
  input  logic [dealloc_els_p-1:0]             dealloc_v_i,
  input  logic [dealloc_els_p*id_width_lp-1:0] dealloc_id_i,
  output logic [cnt_width_lp-1:0]              free_cnt_o,
  output logic                                 empty_o
);

  localparam logic [id_width_lp-1:0] last_id_lp = id_width_lp'(els_p - 1);

  logic [els_p-1:0]        r_allocated;
  logic [id_width_lp-1:0]  r_start;
  logic [cnt_width_lp-1:0] r_free_cnt;

  logic [dealloc_els_p-1:0][id_width_lp-1:0] w_dealloc_id;
  logic [els_p-1:0]                          w_dealloc_mask;
  logic [els_p-1:0]                          w_avail;
  logic [alloc_els_p-1:0][els_p-1:0]         w_pick_oh;
  logic [alloc_els_p-1:0]                    w_pick_v;
  logic [alloc_els_p-1:0][id_width_lp-1:0]   w_pick_id;
  logic [els_p-1:0]                          w_alloc_mask;
  logic [cnt_width_lp:0]                     w_n_dealloc;
  logic [cnt_width_lp:0]                     w_n_yumi;
  logic [cnt_width_lp:0]                     w_free_next;
  logic [id_width_lp-1:0]                    w_start_next;

  // Dealloc decoders. Out-of-range IDs decode to nothing; an assertion flags them.
  always_comb begin
    w_dealloc_mask = '0;
    for (int j = 0; j < dealloc_els_p; j++) begin
      w_dealloc_id[j] = dealloc_id_i[j*id_width_lp +: id_width_lp];
      if (dealloc_v_i[j] && (32'(w_dealloc_id[j]) < els_p)) begin
        w_dealloc_mask[w_dealloc_id[j]] = 1'b1;
      end
    end
  end

  // Returned IDs are removed before the availability check. This creates the bypass.
  assign w_avail = ~((r_allocated & ~w_dealloc_mask) | reserve_i);

  bsg_id_pool_multi_port_pick #(
    .els_p       (els_p),
    .alloc_els_p (alloc_els_p),
    .id_width_lp (id_width_lp)
  ) u_pick (
    .i_avail   (w_avail),
    .i_start   (r_start),
    .o_pick_oh (w_pick_oh),
    .o_pick_v  (w_pick_v)
  );

  // One-hot to binary encoders, and the mask of IDs consumed this cycle.
  always_comb begin
    w_alloc_mask = '0;
    for (int k = 0; k < alloc_els_p; k++) begin
      w_pick_id[k] = '0;
      for (int i = 0; i < els_p; i++) begin
        if (w_pick_oh[k][i]) w_pick_id[k] = w_pick_id[k] | id_width_lp'(i);
      end
      alloc_id_o[k*id_width_lp +: id_width_lp] = w_pick_id[k];
      if (alloc_yumi_i[k]) w_alloc_mask = w_alloc_mask | w_pick_oh[k];
    end
  end

  assign alloc_v_o = w_pick_v;

  // The free count uses one extra bit so the intermediate sum cannot wrap.
  always_comb begin
    w_n_dealloc = '0;
    w_n_yumi    = '0;
    for (int j = 0; j < dealloc_els_p; j++) begin
      w_n_dealloc = w_n_dealloc + {{cnt_width_lp{1'b0}}, dealloc_v_i[j]};
    end
    for (int k = 0; k < alloc_els_p; k++) begin
      w_n_yumi = w_n_yumi + {{cnt_width_lp{1'b0}}, alloc_yumi_i[k]};
    end
    w_free_next = {1'b0, r_free_cnt} + w_n_dealloc - w_n_yumi;
  end

  // Picks are in search order. The highest consuming port therefore holds the
  // last consumed ID, and the next search starts just after it.
  always_comb begin
    w_start_next = r_start;
    if (rotate_p != 0) begin
      for (int k = 0; k < alloc_els_p; k++) begin
        if (alloc_yumi_i[k]) begin
          w_start_next = (w_pick_id[k] == last_id_lp) ? '0 : w_pick_id[k] + id_width_lp'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_allocated <= '0;
      r_start     <= '0;
      r_free_cnt  <= cnt_width_lp'(els_p);
    end else begin
      r_allocated <= (r_allocated & ~w_dealloc_mask) | w_alloc_mask;
      r_start     <= w_start_next;
      r_free_cnt  <= w_free_next[cnt_width_lp-1:0];
    end
  end

  assign free_cnt_o = r_free_cnt;
  assign empty_o    = ~|r_allocated;

  // Illegal-use checks. Requiring a returned ID to be set in r_allocated also
  // rejects returning an ID that is only being allocated in the same cycle.
  for (genvar j = 0; j < dealloc_els_p; j++) begin : g_dealloc_chk
    a_dealloc_range: assert property (@(posedge clk_i) disable iff (reset_i)
      dealloc_v_i[j] |-> (32'(w_dealloc_id[j]) < els_p))
      else $error("dealloc port %0d: id %0d out of range", j, w_dealloc_id[j]);
    a_dealloc_owned: assert property (@(posedge clk_i) disable iff (reset_i)
      (dealloc_v_i[j] && (32'(w_dealloc_id[j]) < els_p)) |-> r_allocated[w_dealloc_id[j]])
      else $error("dealloc port %0d: id %0d not allocated", j, w_dealloc_id[j]);
    a_dealloc_reserved: assert property (@(posedge clk_i) disable iff (reset_i)
      (dealloc_v_i[j] && (32'(w_dealloc_id[j]) < els_p)) |-> !reserve_i[w_dealloc_id[j]])
      else $warning("dealloc port %0d: id %0d is reserved", j, w_dealloc_id[j]);
    for (genvar m = j + 1; m < dealloc_els_p; m++) begin : g_pair
      a_dealloc_dup: assert property (@(posedge clk_i) disable iff (reset_i)
        !(dealloc_v_i[j] && dealloc_v_i[m] && (w_dealloc_id[j] == w_dealloc_id[m])))
        else $error("dealloc ports %0d/%0d return the same id", j, m);
    end
  end

  for (genvar k = 0; k < alloc_els_p; k++) begin : g_yumi_chk
    a_yumi_v: assert property (@(posedge clk_i) disable iff (reset_i)
      alloc_yumi_i[k] |-> alloc_v_o[k])
      else $error("alloc port %0d: yumi without v", k);
  end

endmodule

// File: tb/tb_bsg_id_pool_multi_port.sv
module tb_bsg_id_pool_multi_port;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance 0: els_p=8, lowest-first. Instance 1: els_p=4, rotating.
  logic [7:0] res0;
  logic [1:0] av0, yumi0, dv0;
  logic [5:0] aid0, did0;
  logic [3:0] fc0;
  logic       e0;

  logic [3:0] res1;
  logic [1:0] av1, yumi1, dv1;
  logic [3:0] aid1, did1;
  logic [2:0] fc1;
  logic       e1;

  bsg_id_pool_multi_port #(.els_p(8), .alloc_els_p(2), .dealloc_els_p(2), .rotate_p(0)) u_dut (
    .clk_i(clk), .reset_i(rst), .reserve_i(res0),
    .alloc_v_o(av0), .alloc_id_o(aid0), .alloc_yumi_i(yumi0),
    .dealloc_v_i(dv0), .dealloc_id_i(did0),
    .free_cnt_o(fc0), .empty_o(e0)
  );

  bsg_id_pool_multi_port #(.els_p(4), .alloc_els_p(2), .dealloc_els_p(2), .rotate_p(1)) u_rot (
    .clk_i(clk), .reset_i(rst), .reserve_i(res1),
    .alloc_v_o(av1), .alloc_id_o(aid1), .alloc_yumi_i(yumi1),
    .dealloc_v_i(dv1), .dealloc_id_i(did1),
    .free_cnt_o(fc1), .empty_o(e1)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Set of held IDs, a search start, and a free counter per instance.
  bit m_alloc[2][8];
  int m_start[2];
  int m_cnt[2];

  function automatic int n_of(input int u);
    return (u == 0) ? 8 : 4;
  endfunction

  function automatic void model_reset(input int u);
    for (int i = 0; i < 8; i++) m_alloc[u][i] = 1'b0;
    m_start[u] = 0;
    m_cnt[u]   = n_of(u);
  endfunction

  function automatic bit model_empty(input int u);
    bit any;
    any = 1'b0;
    for (int i = 0; i < 8; i++) any = any | m_alloc[u][i];
    return !any;
  endfunction

  // Walk IDs in search order. Hand the first two free, unreserved IDs to ports 0 and 1.
  function automatic void model_offers(input int u, input logic [7:0] res, input logic [1:0] dv,
                                       input int d0, input int d1,
                                       output logic [1:0] ev, output int ea, output int eb);
    int n;
    int found;
    int id;
    bit held;
    n = n_of(u);
    found = 0;
    ev = 2'b00; ea = 0; eb = 0;
    for (int i = 0; i < n; i++) begin
      id   = (m_start[u] + i) % n;
      held = m_alloc[u][id] && !((dv[0] && d0 == id) || (dv[1] && d1 == id));
      if (!held && !res[id]) begin
        if (found == 0) begin ev[0] = 1'b1; ea = id; end
        else if (found == 1) begin ev[1] = 1'b1; eb = id; end
        found++;
      end
    end
  endfunction

  function automatic void model_commit(input int u, input logic [7:0] res, input logic [1:0] dv,
                                       input int d0, input int d1, input logic [1:0] yumi);
    logic [1:0] ev;
    int ea, eb;
    model_offers(u, res, dv, d0, d1, ev, ea, eb);
    if (dv[0]) begin m_alloc[u][d0] = 1'b0; m_cnt[u]++; end
    if (dv[1]) begin m_alloc[u][d1] = 1'b0; m_cnt[u]++; end
    if (yumi[0]) begin m_alloc[u][ea] = 1'b1; m_cnt[u]--; end
    if (yumi[1]) begin m_alloc[u][eb] = 1'b1; m_cnt[u]--; end
    if (u == 1) begin
      if (yumi[1]) m_start[u] = (eb + 1) % n_of(u);
      else if (yumi[0]) m_start[u] = (ea + 1) % n_of(u);
    end
  endfunction

  // Legal random stimulus. Reserves avoid held IDs, deallocs return held IDs only,
  // and yumi is raised only on ports the model says are valid.
  function automatic void gen(input int u, output logic [7:0] res, output logic [1:0] dv,
                              output int d0, output int d1, output logic [1:0] yumi);
    int n;
    logic [1:0] ev;
    int ea, eb;
    n = n_of(u);
    res = '0; dv = '0; d0 = 0; d1 = 0; yumi = '0;
    for (int i = 0; i < n; i++) begin
      if (!m_alloc[u][i] && $urandom_range(0, 3) == 0) res[i] = 1'b1;
    end
    if ($urandom_range(0, 2) == 0) begin
      d0 = $urandom_range(0, n - 1);
      if (m_alloc[u][d0]) dv[0] = 1'b1;
    end
    if ($urandom_range(0, 2) == 0) begin
      d1 = $urandom_range(0, n - 1);
      if (m_alloc[u][d1] && !(dv[0] && d0 == d1)) dv[1] = 1'b1;
    end
    model_offers(u, res, dv, d0, d1, ev, ea, eb);
    yumi = ev & 2'($urandom_range(0, 3));
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_unit(input int u, input logic [7:0] res, input logic [1:0] dv,
                            input int d0, input int d1, input logic [1:0] av,
                            input logic [31:0] id0, input logic [31:0] id1,
                            input logic [31:0] fc, input logic emp);
    logic [1:0] ev;
    int ea, eb;
    logic [31:0] distinct;
    model_offers(u, res, dv, d0, d1, ev, ea, eb);
    chk($sformatf("u%0d_alloc_v", u), {30'b0, av}, {30'b0, ev});
    if (ev[0]) chk($sformatf("u%0d_id_p0", u), id0, ea);
    if (ev[1]) chk($sformatf("u%0d_id_p1", u), id1, eb);
    if (ev == 2'b11) begin
      distinct = {31'b0, id0 != id1};
      chk($sformatf("u%0d_distinct", u), distinct, 1);
    end
    chk($sformatf("u%0d_free_cnt", u), fc, m_cnt[u]);
    chk($sformatf("u%0d_empty", u), {31'b0, emp}, {31'b0, model_empty(u)});
  endtask

  // Sample both instances away from the active edge.
  task automatic sample();
    @(negedge clk);
    if (!rst) begin
      check_unit(0, res0, dv0, int'(did0[2:0]), int'(did0[5:3]), av0, aid0[2:0], aid0[5:3], fc0, e0);
      check_unit(1, {4'b0, res1}, dv1, int'(did1[1:0]), int'(did1[3:2]), av1, aid1[1:0], aid1[3:2], fc1, e1);
    end
  endtask

  // Advance one clock and update the model with the inputs that were applied.
  task automatic commit();
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_commit(0, res0, dv0, int'(did0[2:0]), int'(did0[5:3]), yumi0);
      model_commit(1, {4'b0, res1}, dv1, int'(did1[1:0]), int'(did1[3:2]), yumi1);
    end
  endtask

  task automatic idle_inputs();
    res0 = '0; yumi0 = '0; dv0 = '0; did0 = '0;
    res1 = '0; yumi1 = '0; dv1 = '0; did1 = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] r;
    logic [1:0] dv, y;
    int a, b;

    idle_inputs();
    model_reset(0);
    model_reset(1);
    rst = 1'b1;
    commit();
    commit();
    rst = 1'b0;

    // Lowest-first, both ports consuming.
    yumi0 = 2'b11;
    sample();
    chk("t1_c0_p0", aid0[2:0], 0); chk("t1_c0_p1", aid0[5:3], 1);
    chk("t1_c0_cnt", fc0, 8);      chk("t1_c0_empty", e0, 1);
    commit();
    sample();
    chk("t1_c1_p0", aid0[2:0], 2); chk("t1_c1_p1", aid0[5:3], 3);
    chk("t1_c1_cnt", fc0, 6);
    commit();
    yumi0 = 2'b00;
    sample();
    chk("t1_c2_cnt", fc0, 4);
    commit();

    rst = 1'b1; commit(); rst = 1'b0;

    // Reserve mask skips IDs 0 and 2, then is released.
    res0 = 8'b0000_0101;
    sample();
    chk("t2_res_p0", aid0[2:0], 1); chk("t2_res_p1", aid0[5:3], 3);
    commit();
    res0 = 8'b0;
    sample();
    chk("t2_clr_p0", aid0[2:0], 0); chk("t2_clr_p1", aid0[5:3], 1);
    commit();

    // Fill the pool, then dealloc two IDs and reclaim them through the bypass.
    yumi0 = 2'b11;
    for (int i = 0; i < 4; i++) begin sample(); commit(); end
    yumi0 = 2'b00;
    sample();
    chk("t3_full_v", av0, 0); chk("t3_full_cnt", fc0, 0);
    commit();
    dv0 = 2'b11; did0 = {3'd2, 3'd5}; yumi0 = 2'b11;
    sample();
    chk("t3_byp_v", av0, 3);
    chk("t3_byp_p0", aid0[2:0], 2); chk("t3_byp_p1", aid0[5:3], 5);
    commit();
    dv0 = 2'b00; did0 = '0; yumi0 = 2'b00;
    sample();
    chk("t3_after_cnt", fc0, 0); chk("t3_after_v", av0, 0);
    commit();

    // A single free ID is offered on port 0 only.
    dv0 = 2'b01; did0 = {3'd0, 3'd6};
    sample(); commit();
    dv0 = 2'b00; did0 = '0;
    sample();
    chk("t5_one_v", av0, 1); chk("t5_one_p0", aid0[2:0], 6);
    yumi0 = 2'b01;
    commit();
    yumi0 = 2'b00;
    sample();
    chk("t5_none_v", av0, 0);
    commit();

    // Leave 5 IDs held, then reset while traffic is active.
    dv0 = 2'b11; did0 = {3'd1, 3'd0};
    sample(); commit();
    dv0 = 2'b01; did0 = {3'd0, 3'd2};
    sample();
    chk("t6_pre_cnt", fc0, 2);
    commit();
    rst = 1'b1; dv0 = 2'b11; did0 = {3'd4, 3'd3}; yumi0 = 2'b11;
    commit();
    rst = 1'b0;
    idle_inputs();
    sample();
    chk("t6_empty", e0, 1); chk("t6_cnt", fc0, 8); chk("t6_p0", aid0[2:0], 0);
    commit();

    // Rotating search start on the 4-entry pool.
    yumi1 = 2'b01;
    sample();
    chk("t4_first", aid1[1:0], 0);
    commit();
    yumi1 = 2'b00;
    sample();
    chk("t4_next", aid1[1:0], 1);
    commit();
    dv1 = 2'b01; did1 = {2'd0, 2'd0};
    sample(); commit();
    dv1 = 2'b00; did1 = '0;
    yumi1 = 2'b01;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("t4_wrap%0d", i), aid1[1:0], (i + 1) % 4);
      commit();
    end
    yumi1 = 2'b00;

    // Random legal traffic on both instances, with occasional resets.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      gen(0, r, dv, a, b, y);
      res0 = r; dv0 = dv; did0 = {3'(b), 3'(a)}; yumi0 = y;
      gen(1, r, dv, a, b, y);
      res1 = r[3:0]; dv1 = dv; did1 = {2'(b), 2'(a)}; yumi1 = y;
      sample();
      commit();
    end
    rst = 1'b0;
    idle_inputs();
    sample();
    commit();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
